// File: rtl/kamacore_pkg.sv
// Shared constants and types for the kamacore load/store unit.
// Holds the data width, the load/store opcodes and funct3 codes, and the LSU state encoding.
package kamacore_pkg;

    localparam int CPU_WIDTH = 32;

    localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/kamacore_lsu_align.sv
// Byte-lane logic for the LSU: fault detection, write strobes, replicated store data,
// and load lane extraction with sign or zero extension.
module kamacore_lsu_align
    import kamacore_pkg::*;
(
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic [1:0]           addr,
    input  logic [CPU_WIDTH-1:0] store_data,
    input  logic [CPU_WIDTH-1:0] rdata,
    output logic                 is_store,
    output logic                 fault,
    output logic [3:0]           wstrb,
    output logic [CPU_WIDTH-1:0] wdata,
    output logic [CPU_WIDTH-1:0] load_data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        case (addr)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        is_store  = (opcode == OPCODE_STORE);
        fault     = 1'b0;
        wstrb     = 4'b0000;
        wdata     = '0;
        load_data = '0;
        if (opcode == OPCODE_LOAD) begin
            case (funct3)
                F3_LB:  load_data = {{24{lane_b[7]}}, lane_b};
                F3_LBU: load_data = {24'b0, lane_b};
                F3_LH: begin
                    fault     = addr[0];
                    load_data = {{16{lane_h[15]}}, lane_h};
                end
                F3_LHU: begin
                    fault     = addr[0];
                    load_data = {16'b0, lane_h};
                end
                F3_LW: begin
                    fault     = (addr != 2'b00);
                    load_data = rdata;
                end
                default: fault = 1'b1;
            endcase
        end else if (is_store) begin
            case (funct3)
                F3_SB: begin
                    wstrb = 4'b0001 << addr;
                    wdata = {4{store_data[7:0]}};
                end
                F3_SH: begin
                    fault = addr[0];
                    wstrb = 4'b0011 << {addr[1], 1'b0};
                    wdata = {2{store_data[15:0]}};
                end
                F3_SW: begin
                    fault = (addr != 2'b00);
                    wstrb = 4'b1111;
                    wdata = store_data;
                end
                default: fault = 1'b1;
            endcase
        end else begin
            fault = 1'b1;
        end
    end

endmodule

// File: rtl/kamacore_lsu.sv
// Single-outstanding load/store unit: accepts one access from execute, runs one memory
// transaction, and returns the result (or a fault) on the writeback port.
module kamacore_lsu
    import kamacore_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [CPU_WIDTH-1:0] instruction,
    input  logic [CPU_WIDTH-1:0] alu_result,
    input  logic [CPU_WIDTH-1:0] store_data,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [CPU_WIDTH-1:0] mem_addr,
    output logic                 mem_we,
    output logic [3:0]           mem_wstrb,
    output logic [CPU_WIDTH-1:0] mem_wdata,
    input  logic                 mem_rsp_valid,
    input  logic [CPU_WIDTH-1:0] mem_rdata,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic                 wb_we,
    output logic [4:0]           wb_rd,
    output logic [CPU_WIDTH-1:0] wb_data,
    output logic                 wb_fault,
    output lsu_state_e           state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // once valid is raised, it and its payload stay unchanged until that edge.
    // mem_rsp_valid is a one-cycle pulse with no ready, honoured only in WAIT_RSP.

    logic [6:0]           lat_opcode;
    logic [2:0]           lat_funct3;
    logic [1:0]           lat_addr;

    logic [6:0]           a_opcode;
    logic [2:0]           a_funct3;
    logic [1:0]           a_addr;
    logic                 a_is_store;
    logic                 a_fault;
    logic [3:0]           a_wstrb;
    logic [CPU_WIDTH-1:0] a_wdata;
    logic [CPU_WIDTH-1:0] a_load_data;

    logic                 unused_instr_bits;
    assign unused_instr_bits = ^instruction[31:15];

    // Decode the incoming access while idle, the latched one while it is in flight.
    always_comb begin
        if (state == IDLE) begin
            a_opcode = instruction[6:0];
            a_funct3 = instruction[14:12];
            a_addr   = alu_result[1:0];
        end else begin
            a_opcode = lat_opcode;
            a_funct3 = lat_funct3;
            a_addr   = lat_addr;
        end
    end

    kamacore_lsu_align u_align (
        .opcode     (a_opcode),
        .funct3     (a_funct3),
        .addr       (a_addr),
        .store_data (store_data),
        .rdata      (mem_rdata),
        .is_store   (a_is_store),
        .fault      (a_fault),
        .wstrb      (a_wstrb),
        .wdata      (a_wdata),
        .load_data  (a_load_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_we        <= 1'b0;
            mem_wstrb     <= 4'b0000;
            mem_wdata     <= '0;
            wb_valid      <= 1'b0;
            wb_we         <= 1'b0;
            wb_rd         <= 5'd0;
            wb_data       <= '0;
            wb_fault      <= 1'b0;
            lat_opcode    <= 7'd0;
            lat_funct3    <= 3'd0;
            lat_addr      <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_opcode <= instruction[6:0];
                        lat_funct3 <= instruction[14:12];
                        lat_addr   <= alu_result[1:0];
                        wb_rd      <= instruction[11:7];
                        req_ready  <= 1'b0;
                        if (a_fault) begin
                            state    <= DONE;
                            wb_valid <= 1'b1;
                            wb_fault <= 1'b1;
                            wb_we    <= 1'b0;
                            wb_data  <= '0;
                        end else begin
                            state         <= REQ;
                            mem_req_valid <= 1'b1;
                            mem_addr      <= {alu_result[CPU_WIDTH-1:2], 2'b00};
                            mem_we        <= a_is_store;
                            mem_wstrb     <= a_wstrb;
                            mem_wdata     <= a_wdata;
                            wb_fault      <= 1'b0;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    // Stores complete on this acknowledge too; they just write nothing back.
                    if (mem_rsp_valid) begin
                        state    <= DONE;
                        wb_valid <= 1'b1;
                        wb_fault <= 1'b0;
                        if (lat_opcode == OPCODE_LOAD) begin
                            wb_we   <= (wb_rd != 5'd0);
                            wb_data <= a_load_data;
                        end else begin
                            wb_we   <= 1'b0;
                            wb_data <= '0;
                        end
                    end
                end
                DONE: begin
                    if (wb_ready) begin
                        wb_valid  <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/kamacore_lsu.md
KAMACORE_LSU -- requirements
Module: kamacore_lsu

Interface
REQ-001 Parameters: none; width SHALL be CPU_WIDTH (32) from kamacore_pkg.
REQ-002 clk  in  1  sole clock; all state SHALL update on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 req_valid  in  1  execute stage presents a load/store.
REQ-005 req_ready  out  1  LSU can accept; high only in IDLE.
REQ-006 instruction  in  CPU_WIDTH  full instruction; opcode [6:0], funct3 [14:12], rd [11:7].
REQ-007 alu_result  in  CPU_WIDTH  effective address (rs1 + imm) from kamacore_alu.
REQ-008 store_data  in  CPU_WIDTH  rs2 value.
REQ-009 mem_req_valid / mem_req_ready  out / in  1 / 1  memory request handshake.
REQ-010 mem_addr  out  CPU_WIDTH  word-aligned address {addr[31:2],2'b00}.
REQ-011 mem_we, mem_wstrb, mem_wdata  out  1, 4, CPU_WIDTH  write enable, byte strobes, lane-replicated write data.
REQ-012 mem_rsp_valid, mem_rdata  in  1, CPU_WIDTH  single-cycle response pulse; rdata valid with it.
REQ-013 wb_valid / wb_ready  out / in  1 / 1  writeback handshake.
REQ-014 wb_we, wb_rd, wb_data, wb_fault  out  1, 5, CPU_WIDTH, 1  register write enable, destination, value, misaligned/illegal flag.

Function
REQ-015 FSM states SHALL be IDLE, REQ, WAIT_RSP, DONE.
REQ-016 IDLE: on req_valid && req_ready, latch opcode, funct3, rd, alu_result, store_data; go REQ, or DONE with wb_fault=1 if faulting.
REQ-017 Fault: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; load funct3 in {011,110,111}; store funct3 >= 011; opcode neither OPCODE_LOAD nor OPCODE_STORE.
REQ-018 A faulting access SHALL never assert mem_req_valid; DONE presents wb_data=0, wb_we=0, wb_fault=1.
REQ-019 REQ: mem_req_valid=1 with stable addr/we/wstrb/wdata until mem_req_ready; on handshake go WAIT_RSP.
REQ-020 Strobes: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111; loads 4'b0000, mem_we=0.
REQ-021 Write data: SB byte x4, SH halfword x2, SW unchanged.
REQ-022 WAIT_RSP: on mem_rsp_valid, latch result, go DONE; stores also wait for this acknowledge.
REQ-023 Load extract: LB/LBU byte lane addr[1:0], LH/LHU half lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW as-is.
REQ-024 DONE: wb_valid=1, outputs stable until wb_ready; then IDLE. Next accept no earlier than the following cycle.
REQ-025 wb_we=1 only for non-faulting loads with rd!=0; wb_rd=latched rd always.
REQ-026 mem_rsp_valid outside WAIT_RSP SHALL be ignored.
REQ-027 Minimum latency: accept cycle N, mem_req_valid N+1, rsp N+2, wb_valid N+3; fault: wb_valid N+1.
REQ-028 Only one transaction outstanding; no pipelining.

Reset
REQ-029 rst_n=0 at an edge: state IDLE; req_ready=1 after release; mem_req_valid, wb_valid, wb_we, wb_fault=0; wb_data, wb_rd, mem_addr, mem_wdata, mem_wstrb=0.
REQ-030 Reset mid-transaction SHALL abandon it silently; a late mem_rsp_valid after reset SHALL be ignored.

Structure
REQ-031 kamacore_pkg SHALL hold CPU_WIDTH, OPCODE_LOAD (7'b0000011), OPCODE_STORE (7'b0100011), load/store funct3 constants, and the LSU state enum.
REQ-032 Combinational sub-module kamacore_lsu_align SHALL compute strobes, replicated wdata, fault flag, and load extraction/extension.

Verification
REQ-033 LW x5, addr 0x100, rdata 0xDEADBEEF, ready/rsp immediate -> mem_addr 0x100, wb_valid cycle N+3, wb_data 0xDEADBEEF, wb_rd 5, wb_we 1.
REQ-034 LB addr 0x103, rdata 0x80FF_0000 -> wb_data 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x000080FF.
REQ-035 SB addr 0x201, store_data 0x12345678 -> wstrb 4'b0010, wdata 0x78787878, mem_we 1; after rsp wb_valid with wb_we 0.
REQ-036 LW addr 0x102 -> no mem_req_valid, wb_valid N+1, wb_fault 1, wb_data 0.
REQ-037 mem_req_ready low 3 cycles, wb_ready low 2 cycles -> request and wb outputs held stable, req_ready 0 throughout, single mem transaction.
REQ-038 rst_n low in WAIT_RSP, then mem_rsp_valid -> no wb_valid, req_ready 1, next LW completes normally.
